serial_word_comparator: RTL and testbench
=========================================

Name: serial_word_comparator

Overview:
- Multi-cycle magnitude comparator for WIDTH-bit operands.
- Captures A and B on a start handshake, then scans them MSB-first one 2-bit digit pair per cycle using internal 2-bit slice compare logic.
- Terminates early on the first unequal digit.
- Sits between the datapath operand registers and downstream control that consumes the registered less/equal/greater flags and the done strobe.

Parameters:
- WIDTH, 8, operand width in bits. Must be even and >= 2. N = WIDTH/2 digits.

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  synchronous active-low reset
- start  input  1  request; accepted only in IDLE
- A  input  WIDTH  operand A, sampled on the accepting edge only
- B  input  WIDTH  operand B, sampled on the accepting edge only
- busy  output  1  high in SCAN and DONE
- done  output  1  one-cycle pulse, result valid
- A_less_B  output  1  registered result, A < B
- A_equal_B  output  1  registered result, A == B
- A_greater_B  output  1  registered result, A > B

Behaviour:
- Reset: one clock, synchronous active-low reset (rst_n), sampled on rising clk edge. rst_n=0 forces:
  - state = IDLE
  - busy = 0, done = 0
  - all three result flags = 0
  - digit counter = 0
  - shift registers = 0
- States:
  - IDLE: start=1 at an edge latches A and B into the shift registers, loads counter = N-1, goes to SCAN.
  - SCAN: each edge compares the top digit pair (bits WIDTH-1:WIDTH-2) with 2-bit slice logic.
    - Unequal digit: write flags (lt or gt = 1, others 0) and go to DONE.
    - Equal digit, counter = 0: write equal = 1, others 0, and go to DONE.
    - Otherwise: shift both registers left by 2, decrement counter, stay in SCAN.
  - DONE: done = 1 for exactly this one cycle, then IDLE unconditionally.
- Latency:
  - Start accepted at edge 0; decision at edge d, where d = 1-based index of the first differing digit from the MSB, or N if the operands are equal.
  - done is high in the cycle following edge d. Range is 1..N cycles.
- Result flags:
  - Change only at a decision edge or at reset.
  - Hold the last result through IDLE until the next decision.
  - After the first completion, exactly one flag is high.
- start is ignored while busy=1, including the DONE cycle; no queueing.
- Back-to-back: start in the first IDLE cycle after DONE is accepted. Minimum period is d+1 cycles.
- A and B changing during SCAN have no effect.
- Reset mid-SCAN abandons the operation with no done pulse; flags clear to 0.
- Unsigned compare is the default.

Optional Feature:
- Macro: SIGNED_CMP_EN.
- Defined:
  - Adds input port is_signed (1 bit), sampled with A and B on the accepting edge.
  - When is_signed=1, the MSB of both captured operands is inverted at capture (two's complement mapped to offset binary); the scan is unchanged.
  - When is_signed=0, the compare is unsigned.
  - Latency is identical in both modes.
- Not defined: the port is absent and the compare is always unsigned.

Test Plan:
- Equal operands: WIDTH=8, A=0xB4, B=0xB4, start 1 cycle -> busy for 5 cycles; done in cycle 5 after start edge (d=4); A_equal_B=1, others 0.
- MSB-digit early exit: A=0x80, B=0x7F unsigned -> done 1 cycle after accept; A_greater_B=1. With SIGNED_CMP_EN and is_signed=1 -> A_less_B=1, same latency.
- Last-digit difference: A=0x12, B=0x13 -> d=4, A_less_B=1. Then A=0x13, B=0x12 -> A_greater_B=1; flags hold between operations.
- start held high continuously with A=0x40, B=0x40, then A=0x00 during SCAN -> first result equal; DONE-cycle start ignored; next op accepted in the following IDLE cycle with the new operands.
- Reset mid-op: A=0x55, B=0x56, assert rst_n=0 at edge 2 -> no done pulse, busy=0, flags=0. New start after release completes normally with A_less_B=1.
- WIDTH=2 instance: A=2, B=1 -> done 1 cycle after accept, A_greater_B=1. A=3, B=3 -> A_equal_B=1.

Source files
------------

// File: rtl/serial_word_comparator.sv
// Purpose : multi-cycle magnitude comparator; scans A/B MSB-first one 2-bit digit per cycle, stops on first unequal digit.
// Latency : decision d = 1..N edges after the accepting edge (N = WIDTH/2); done pulses the cycle after the decision edge.
// Backpres: start accepted only in IDLE; ignored while busy (SCAN and DONE), no queueing.
//
// Ports: clk, rst_n (sync active-low), start, A, B -> busy, done, A_less_B, A_equal_B, A_greater_B.
// Optional: define SIGNED_CMP_EN to add input is_signed (two's complement compare selected per operation).
module serial_word_comparator #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
`ifdef SIGNED_CMP_EN
    input  logic             is_signed,
`endif
    output logic             busy,
    output logic             done,
    output logic             A_less_B,
    output logic             A_equal_B,
    output logic             A_greater_B
);

    localparam int N  = WIDTH / 2;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             lt_q, lt_d;
    logic             eq_q, eq_d;
    logic             gt_q, gt_d;

    logic [WIDTH-1:0] cap_a, cap_b;
    logic [1:0]       dig_a, dig_b;
    logic             dig_lt, dig_gt;

    // 2-bit slice magnitude compare on the current top digit pair.
    always_comb begin
        dig_a  = a_sh_q[WIDTH-1 -: 2];
        dig_b  = b_sh_q[WIDTH-1 -: 2];
        dig_lt = (!dig_a[1] && dig_b[1]) ||
                 ((dig_a[1] == dig_b[1]) && !dig_a[0] && dig_b[0]);
        dig_gt = (dig_a[1] && !dig_b[1]) ||
                 ((dig_a[1] == dig_b[1]) && dig_a[0] && !dig_b[0]);
    end

    // Signed mode flips the sign bit so offset binary orders like unsigned.
    always_comb begin
        cap_a = A;
        cap_b = B;
`ifdef SIGNED_CMP_EN
        cap_a[WIDTH-1] = A[WIDTH-1] ^ is_signed;
        cap_b[WIDTH-1] = B[WIDTH-1] ^ is_signed;
`endif
    end

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        lt_d    = lt_q;
        eq_d    = eq_q;
        gt_d    = gt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_sh_d  = cap_a;
                    b_sh_d  = cap_b;
                    cnt_d   = CW'(N - 1);
                    busy_d  = 1'b1;
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                if (dig_lt || dig_gt || (cnt_q == '0)) begin
                    // Decision edge: flags are only ever written here (and at reset).
                    lt_d    = dig_lt;
                    gt_d    = dig_gt;
                    eq_d    = !dig_lt && !dig_gt;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    a_sh_d = a_sh_q << 2;
                    b_sh_d = b_sh_q << 2;
                    cnt_d  = cnt_q - CW'(1);
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            lt_q    <= 1'b0;
            eq_q    <= 1'b0;
            gt_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            lt_q    <= lt_d;
            eq_q    <= eq_d;
            gt_q    <= gt_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign A_less_B    = lt_q;
    assign A_equal_B   = eq_q;
    assign A_greater_B = gt_q;

endmodule

// File: tb/tb_serial_word_comparator.sv
// Purpose : directed table-driven bench for serial_word_comparator (WIDTH=8 and WIDTH=2 instances).
// Latency : measures edges from accept to done against hand-computed digit positions.
// Backpres: exercises start held high through DONE and reset abandoning an operation.
module tb_serial_word_comparator;

    logic       clk;
    logic       rst_n;
    logic       start8, start2;
    logic [7:0] a8, b8;
    logic [1:0] a2, b2;
    logic       busy8, done8, lt8, eq8, gt8;
    logic       busy2, done2, lt2, eq2, gt2;
`ifdef SIGNED_CMP_EN
    logic       sgn8, sgn2;
`endif

    int tests = 0;
    int fails = 0;

    serial_word_comparator #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .A(a8), .B(b8),
`ifdef SIGNED_CMP_EN
        .is_signed(sgn8),
`endif
        .busy(busy8), .done(done8),
        .A_less_B(lt8), .A_equal_B(eq8), .A_greater_B(gt8)
    );

    serial_word_comparator #(.WIDTH(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .A(a2), .B(b2),
`ifdef SIGNED_CMP_EN
        .is_signed(sgn2),
`endif
        .busy(busy2), .done(done2),
        .A_less_B(lt2), .A_equal_B(eq2), .A_greater_B(gt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        int         d;
        logic       lt;
        logic       eq;
        logic       gt;
    } vec_t;

    vec_t tbl[9];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_flags8(input string name, input logic lt, input logic eq, input logic gt);
        check({name, " flags"}, {29'd0, lt8, eq8, gt8}, {29'd0, lt, eq, gt});
    endtask

    // One full operation on the 8-bit instance: latency, flags, return to idle, flag hold.
    task automatic run_op8(input logic [7:0] a, input logic [7:0] b, input logic sgn,
                           input int d, input logic lt, input logic eq, input logic gt,
                           input string name);
        int n;
        @(negedge clk);
        a8 = a; b8 = b; start8 = 1'b1;
`ifdef SIGNED_CMP_EN
        sgn8 = sgn;
`else
        if (sgn) $display("note: signed vector skipped build has no is_signed");
`endif
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        a8 = ~a; b8 = ~b;   // operands must not matter after capture
        check({name, " busy after accept"}, int'(busy8), 1);
        n = 0;
        while (!done8 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({name, " latency"}, n, d);
        check_flags8(name, lt, eq, gt);
        @(negedge clk);
        check({name, " idle busy/done"}, {30'd0, busy8, done8}, 0);
        repeat (2) @(negedge clk);
        check_flags8({name, " hold"}, lt, eq, gt);
    endtask

    task automatic run_op2(input logic [1:0] a, input logic [1:0] b,
                           input logic lt, input logic eq, input logic gt, input string name);
        int n;
        @(negedge clk);
        a2 = a; b2 = b; start2 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start2 = 1'b0;
        n = 0;
        while (!done2 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check({name, " latency"}, n, 1);
        check({name, " flags"}, {29'd0, lt2, eq2, gt2}, {29'd0, lt, eq, gt});
        @(negedge clk);
        check({name, " idle busy"}, int'(busy2), 0);
    endtask

    initial begin
        int n;
        tbl[0] = '{8'hB4, 8'hB4, 4, 1'b0, 1'b1, 1'b0};
        tbl[1] = '{8'h80, 8'h7F, 1, 1'b0, 1'b0, 1'b1};
        tbl[2] = '{8'h12, 8'h13, 4, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{8'h13, 8'h12, 4, 1'b0, 1'b0, 1'b1};
        tbl[4] = '{8'h3C, 8'h2C, 2, 1'b0, 1'b0, 1'b1};
        tbl[5] = '{8'h00, 8'hFF, 1, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{8'hA5, 8'hA7, 4, 1'b1, 1'b0, 1'b0};
        tbl[7] = '{8'h4C, 8'h48, 3, 1'b0, 1'b0, 1'b1};
        tbl[8] = '{8'h00, 8'h00, 4, 1'b0, 1'b1, 1'b0};

        rst_n = 1'b0; start8 = 1'b0; start2 = 1'b0;
        a8 = '0; b8 = '0; a2 = '0; b2 = '0;
`ifdef SIGNED_CMP_EN
        sgn8 = 1'b0; sgn2 = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("reset busy/done", {30'd0, busy8, done8}, 0);
        check_flags8("reset", 1'b0, 1'b0, 1'b0);
        check("reset w2 outputs", {27'd0, busy2, done2, lt2, eq2, gt2}, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++)
            run_op8(tbl[i].a, tbl[i].b, 1'b0, tbl[i].d, tbl[i].lt, tbl[i].eq, tbl[i].gt,
                    $sformatf("vec%0d", i));

`ifdef SIGNED_CMP_EN
        run_op8(8'h80, 8'h7F, 1'b1, 1, 1'b1, 1'b0, 1'b0, "signed 80/7F");
        run_op8(8'hFF, 8'h01, 1'b1, 1, 1'b1, 1'b0, 1'b0, "signed FF/01");
        run_op8(8'hFF, 8'h01, 1'b0, 1, 1'b0, 1'b0, 1'b1, "unsigned FF/01");
`endif

        // start held high: DONE-cycle start ignored, next IDLE cycle accepts new operands.
        @(negedge clk);
        a8 = 8'h40; b8 = 8'h40; start8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a8 = 8'h00;
        n = 0;
        while (!done8 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("held start first latency", n, 4);
        check_flags8("held start first", 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        check("held start idle busy/done", {30'd0, busy8, done8}, 0);
        @(negedge clk);
        check("held start re-accept busy", int'(busy8), 1);
        check_flags8("held start flags before decision", 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        start8 = 1'b0;
        check("held start second done", int'(done8), 1);
        check_flags8("held start second", 1'b1, 1'b0, 1'b0);
        repeat (2) @(negedge clk);

        // Reset mid-scan: no done pulse, everything clears.
        @(negedge clk);
        a8 = 8'h55; b8 = 8'h56; start8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        @(negedge clk);
        check("mid-reset done before reset", int'(done8), 0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("mid-reset busy/done", {30'd0, busy8, done8}, 0);
        check_flags8("mid-reset", 1'b0, 1'b0, 1'b0);
        repeat (4) begin
            @(negedge clk);
            check("mid-reset no late done", int'(done8), 0);
        end
        run_op8(8'h55, 8'h56, 1'b0, 4, 1'b1, 1'b0, 1'b0, "after reset");

        run_op2(2'd2, 2'd1, 1'b0, 1'b0, 1'b1, "w2 2/1");
        run_op2(2'd3, 2'd3, 1'b0, 1'b1, 1'b0, "w2 3/3");
        run_op2(2'd0, 2'd3, 1'b1, 1'b0, 1'b0, "w2 0/3");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
